// File: rtl/neuron_activation_unit.sv
// neuron_activation_unit: single-stage activation for a neuron accumulator.
// Converts a double-width fixed-point sum into a single-width activation.
// ACT_TYPE selects the function: "relu", "sigmoid_nor" (full table),
// "sigmoid_LU"/"sigmoid_LU_half" (half table plus symmetry); anything else
// is a plain pass-through of the rescaled sum.
// Optional macro ACT_SATURATE_EN: clamp out-of-range sums (sigmoid address
// and positive relu result) instead of wrapping the bit slice.
// Handshake: outvalid is sum_valid delayed by one cycle; out is refreshed
// every cycle and is meaningful only while outvalid is high (no backpressure).
module neuron_activation_unit #(
    parameter int    DATA_WIDTH       = 16,
    parameter int    WEIGHT_INT_WIDTH = 4,
    parameter int    SIGMOID_SIZE     = 10,
    parameter string ACT_TYPE         = "sigmoid_LU"
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*DATA_WIDTH-1:0]   sum,
    input  logic                      sum_valid,
    output logic [DATA_WIDTH-1:0]     out,
    output logic                      outvalid
);

    localparam int SW   = 2 * DATA_WIDTH;
    localparam int FRAC = DATA_WIDTH - WEIGHT_INT_WIDTH;
    localparam int FX   = SIGMOID_SIZE - WEIGHT_INT_WIDTH;
    localparam int HALF = 2 ** (SIGMOID_SIZE - 1);
    localparam int FULL = 2 ** SIGMOID_SIZE;

    // 1 = relu, 2 = full sigmoid table, 3 = half sigmoid table, 0 = pass-through
    localparam int MODE = (ACT_TYPE == "relu")            ? 1 :
                          (ACT_TYPE == "sigmoid_nor")     ? 2 :
                          (ACT_TYPE == "sigmoid_LU")      ? 3 :
                          (ACT_TYPE == "sigmoid_LU_half") ? 3 : 0;

    localparam logic [DATA_WIDTH-1:0]   ONE_Q   = DATA_WIDTH'(1 << FRAC);
    localparam logic [DATA_WIDTH-1:0]   MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [SIGMOID_SIZE-1:0] X_MAX   = {1'b0, {(SIGMOID_SIZE-1){1'b1}}};
    localparam logic [SIGMOID_SIZE-1:0] X_MIN   = {1'b1, {(SIGMOID_SIZE-1){1'b0}}};

    // round(sigmoid(k / 2^FX) * 2^FRAC), evaluated at elaboration in Q60
    // integer arithmetic so the tables need no real-number support.
    function automatic logic [DATA_WIDTH-1:0] sigmoid_q(input int k);
        logic [127:0] one, t, base, sq, p, den, num;
        int a;
        one  = 128'd1 << 60;
        // exp(-2^-FX) from its alternating Taylor series
        t    = one;
        base = one;
        for (int n = 1; n <= 12; n++) begin
            t = t / (128'(n) << FX);
            if (n % 2 == 1) base = base - t;
            else            base = base + t;
        end
        // exp(-|k| / 2^FX) by square-and-multiply
        a  = (k < 0) ? -k : k;
        p  = one;
        sq = base;
        for (int i = 0; i < 31; i++) begin
            if (a[i]) p = (p * sq) >> 60;
            sq = (sq * sq) >> 60;
        end
        // sigmoid(v) = 1/(1+e^-v); sigmoid(-v) = e^-v/(1+e^-v); round to nearest
        den = one + p;
        num = ((k < 0) ? p : one) << (FRAC + 1);
        num = num + den;
        return DATA_WIDTH'(num / (den << 1));
    endfunction

    logic                      sign_w;
    logic [SIGMOID_SIZE-1:0]   x_raw;
    logic [SIGMOID_SIZE-1:0]   x_w;
    logic [DATA_WIDTH-1:0]     shifted;
    logic [WEIGHT_INT_WIDTH:0] top_w;
    logic                      in_range;
    logic                      relu_ovf;
    logic [DATA_WIDTH-1:0]     out_d;
    logic [DATA_WIDTH-1:0]     out_q;
    logic                      outvalid_q;
    logic                      unused_bits;

    assign sign_w   = sum[SW-1];
    assign x_raw    = sum[SW-1-WEIGHT_INT_WIDTH -: SIGMOID_SIZE];
    assign shifted  = sum[DATA_WIDTH+FRAC-1:FRAC];
    // the sum fits the table range only if the bits above x are a sign extension
    assign top_w    = sum[SW-1 -: WEIGHT_INT_WIDTH+1];
    assign in_range = (top_w == '0) || (top_w == '1);
    assign relu_ovf = ~sign_w & (|sum[SW-2:DATA_WIDTH+FRAC-1]);
    // each mode uses only part of the sum; fold the rest into one sink net
    assign unused_bits = ^{sum, x_w, shifted, in_range, relu_ovf};

    // table address: plain slice, or clamped to the table ends when saturating
    always_comb begin
        x_w = x_raw;
`ifdef ACT_SATURATE_EN
        if (!in_range) x_w = sign_w ? X_MIN : X_MAX;
`endif
    end

    generate
        if (MODE == 1) begin : g_relu
            // negative sums clip to zero; positive sums are rescaled
            always_comb begin
                out_d = shifted;
                if (sign_w) begin
                    out_d = '0;
                end
`ifdef ACT_SATURATE_EN
                else if (relu_ovf) begin
                    out_d = MAX_POS;
                end
`endif
            end
        end else if (MODE == 2) begin : g_nor
            logic [DATA_WIDTH-1:0] rom [0:FULL-1];
            for (genvar g = 0; g < FULL; g++) begin : g_ent
                localparam int K = (g >= HALF) ? g - FULL : g;
                localparam logic [DATA_WIDTH-1:0] V = sigmoid_q(K);
                assign rom[g] = V;
            end
            // direct lookup over the full signed x range
            always_comb begin
                out_d = rom[x_w];
            end
        end else if (MODE == 3) begin : g_lu
            logic [DATA_WIDTH-1:0]   rom [0:HALF-1];
            logic [SIGMOID_SIZE-1:0] neg_x;
            logic [SIGMOID_SIZE-2:0] idx;
            for (genvar g = 0; g < HALF; g++) begin : g_ent
                localparam logic [DATA_WIDTH-1:0] V = sigmoid_q(g);
                assign rom[g] = V;
            end
            // negative inputs use sigmoid(-v) = 1 - sigmoid(v); |X_MIN| is
            // one past the table end so it reuses the last entry
            always_comb begin
                neg_x = -x_w;
                idx   = x_w[SIGMOID_SIZE-2:0];
                out_d = rom[idx];
                if (sign_w) begin
                    idx   = (x_w == X_MIN) ? X_MAX[SIGMOID_SIZE-2:0] : neg_x[SIGMOID_SIZE-2:0];
                    out_d = ONE_Q - rom[idx];
                end
            end
        end else begin : g_pass
            // unknown activation type: rescaled sum, no saturation
            always_comb begin
                out_d = shifted;
            end
        end
    endgenerate

    // single pipeline stage: result and its valid flag move together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            outvalid_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            outvalid_q <= sum_valid;
        end
    end

    assign out      = out_q;
    assign outvalid = outvalid_q;

endmodule

// File: tb/tb_neuron_activation_unit.sv
// Bench for neuron_activation_unit: one instance per activation type, all fed
// the same sum stream; expected results are queued at drive time and compared
// when the outputs emerge one cycle later.
module tb_neuron_activation_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sum;
  logic        sum_valid;
  logic [15:0] out_relu, out_nor, out_lu, out_half, out_pass;
  logic        vld_relu, vld_nor, vld_lu, vld_half, vld_pass;

  logic [5*16-1:0] exp_q[$];
  logic            exp_vld;
  int              vec_cnt = 0;
  int              err_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  neuron_activation_unit #(.ACT_TYPE("relu")) u_relu (
    .clk(clk), .rst(rst), .sum(sum), .sum_valid(sum_valid), .out(out_relu), .outvalid(vld_relu));
  neuron_activation_unit #(.ACT_TYPE("sigmoid_nor")) u_nor (
    .clk(clk), .rst(rst), .sum(sum), .sum_valid(sum_valid), .out(out_nor), .outvalid(vld_nor));
  neuron_activation_unit #(.ACT_TYPE("sigmoid_LU")) u_lu (
    .clk(clk), .rst(rst), .sum(sum), .sum_valid(sum_valid), .out(out_lu), .outvalid(vld_lu));
  neuron_activation_unit #(.ACT_TYPE("sigmoid_LU_half")) u_half (
    .clk(clk), .rst(rst), .sum(sum), .sum_valid(sum_valid), .out(out_half), .outvalid(vld_half));
  neuron_activation_unit #(.ACT_TYPE("linear")) u_pass (
    .clk(clk), .rst(rst), .sum(sum), .sum_valid(sum_valid), .out(out_pass), .outvalid(vld_pass));

  // expected outvalid: sum_valid one cycle late, cleared by reset
  always @(posedge clk or posedge rst) begin
    if (rst) exp_vld <= 1'b0;
    else     exp_vld <= sum_valid;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, want, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int round_sig(input real v);
    return $rtoi(4096.0 / (1.0 + $exp(-v)) + 0.5);
  endfunction

  // table address as a signed integer, in units of 1/64
  function automatic int x_of(input logic [31:0] s);
    logic signed [9:0] xr;
    int xs;
    int sv;
    xr = s[27:18];
    xs = int'(xr);
    sv = $signed(s);
`ifdef ACT_SATURATE_EN
    if (sv >= 32'sh08000000)  xs = 511;
    if (sv < -32'sh08000000)  xs = -512;
`endif
    return xs;
  endfunction

  function automatic int model_relu(input logic [31:0] s);
    int sv;
    int q;
    sv = $signed(s);
    if (sv < 0) return 0;
    q = sv >>> 12;
`ifdef ACT_SATURATE_EN
    if (q > 32767) return 32767;
`endif
    return q & 32'hFFFF;
  endfunction

  function automatic int model_pass(input logic [31:0] s);
    int sv;
    sv = $signed(s);
    return (sv >>> 12) & 32'hFFFF;
  endfunction

  function automatic int model_nor(input logic [31:0] s);
    return round_sig(real'(x_of(s)) / 64.0);
  endfunction

  function automatic int model_lu(input logic [31:0] s);
    int x;
    int m;
    x = x_of(s);
    if (s[31] == 1'b0) return round_sig(real'(x & 511) / 64.0);
    m = -x;
    if (m >= 512) m = 511;
    return 4096 - round_sig(real'(m) / 64.0);
  endfunction

  function automatic logic [31:0] fx(input real v);
    return $rtoi(v * 16777216.0);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] s, input logic v);
    logic [15:0] e_relu, e_nor, e_lu, e_pass;
    @(posedge clk);
    #1;
    sum       = s;
    sum_valid = v;
    if (v) begin
      e_relu = 16'(model_relu(s));
      e_nor  = 16'(model_nor(s));
      e_lu   = 16'(model_lu(s));
      e_pass = 16'(model_pass(s));
      exp_q.push_back({e_relu, e_nor, e_lu, e_lu, e_pass});
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_relu"}, out_relu, 0);
    check({tag, "_out_nor"},  out_nor,  0);
    check({tag, "_out_lu"},   out_lu,   0);
    check({tag, "_out_half"}, out_half, 0);
    check({tag, "_out_pass"}, out_pass, 0);
    check({tag, "_valid"}, {vld_relu, vld_nor, vld_lu, vld_half, vld_pass}, 0);
  endtask

  // asynchronous reset in the middle of a valid stream
  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_cleared("rst_async");
    sum       = fx(1.0);
    sum_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_cleared("rst_held");
    @(posedge clk);
    #1;
    sum_valid = 1'b0;
    rst       = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  logic [5*16-1:0] got_e;
  always @(negedge clk) begin
    if (!rst) begin
      check("outvalid", {vld_relu, vld_nor, vld_lu, vld_half, vld_pass}, {5{exp_vld}});
      if (exp_vld) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", exp_q.size(), 1);
        end else begin
          got_e = exp_q.pop_front();
          check("relu",        out_relu, got_e[79:64]);
          check("sigmoid_nor", out_nor,  got_e[63:48]);
          check("sigmoid_LU",  out_lu,   got_e[47:32]);
          check("sigmoid_LU_half", out_half, got_e[31:16]);
          check("passthru",    out_pass, got_e[15:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  real b2b[9] = '{0.0, 0.5, -0.5, 1.0, -1.0, 2.0, -2.0, 4.0, -4.0};

  initial begin
    rst       = 1'b1;
    sum       = '0;
    sum_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_cleared("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed points including out-of-range sums
    drive(32'h0000_0000, 1'b1);
    drive(fx(1.0),  1'b1);
    drive(fx(-1.0), 1'b1);
    drive(0, 1'b0);
    drive(fx(20.0), 1'b1);
    drive(0, 1'b0);
    drive(fx(-20.0), 1'b1);
    drive(fx(12.0), 1'b1);
    drive(fx(7.984375), 1'b1);
    drive(fx(-8.0), 1'b1);
    drive(32'hFFFF_FFFF, 1'b1);
    drive(0, 1'b0);

    // back-to-back valid stream
    foreach (b2b[i]) drive(fx(b2b[i]), 1'b1);
    drive(0, 1'b0);

    // reset in the middle of a stream, then resume
    drive(fx(0.5), 1'b1);
    drive(fx(2.0), 1'b1);
    reset_mid();
    drive(fx(-2.0), 1'b1);
    drive(0, 1'b0);

    // random in-range sums with random valid gaps
    for (int i = 0; i < 60; i++) begin
      logic [31:0] r;
      r = 32'($urandom_range(0, 32'h0FFF_FFFF)) - 32'h0800_0000;
      drive(r, 1'($urandom_range(0, 3) != 0));
    end

    repeat (3) drive(0, 1'b0);
    check("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
